tt_classify_ctrl: RTL and testbench
===================================

TT_CLASSIFY_CTRL -- requirements
Module: tt_classify_ctrl

Interface
REQ-001 Parameter LAT, default 1, range 0..3: cycles from x_drv change to matching f_val on the input.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to classify the attached 7-input function.
REQ-005 x_drv  output  7  input pattern driven to the function under test; bit k feeds xk.
REQ-006 f_val  input  1  function output, valid LAT cycles after the corresponding x_drv.
REQ-007 busy  output  1  high from the cycle after an accepted start until done.
REQ-008 done  output  1  one-cycle pulse when all results are valid.
REQ-009 tt  output  128  truth table; tt[i] = f(x_drv=i).
REQ-010 ones  output  8  count of 1s in tt, 0..128.
REQ-011 self_dual  output  1  1 iff f(~x) = ~f(x) for all x.
REQ-012 monotone  output  1  1 iff raising any single input never lowers f.

Function
REQ-013 FSM states: IDLE, SCAN, DRAIN, CHECK, DONE.
REQ-014 IDLE: start=1 moves the FSM to SCAN next cycle; tt is cleared, ones is cleared, self_dual and monotone are set to 1.
REQ-015 SCAN: x_drv = 0 on the first cycle, then +1 each cycle; exits after the cycle with x_drv = 127 (128 cycles).
REQ-016 An index/valid delay line of LAT stages tags each f_val sample; the tagged sample writes tt[index] and adds to ones.
REQ-017 LAT = 0: f_val is sampled in the same cycle as x_drv.
REQ-018 DRAIN lasts exactly LAT cycles (0 cycles when LAT = 0), then goes to CHECK; x_drv holds 127.
REQ-019 CHECK walks i = 0..127, one index per cycle (128 cycles).
REQ-020 In CHECK, self_dual clears if tt[i] == tt[127-i].
REQ-021 In CHECK, monotone clears if, for any bit j with i[j] = 0, tt[i] = 1 and tt[i | 2^j] = 0 (7 comparisons per cycle).
REQ-022 DONE lasts one cycle with done = 1, then returns to IDLE; busy = 0 in DONE.
REQ-023 Total latency: done asserts 1 + 128 + LAT + 128 cycles after the start cycle.
REQ-024 tt, ones, self_dual and monotone hold their values after done until the next accepted start.
REQ-025 start while busy or in DONE is ignored, with no effect on state or results.
REQ-026 ones saturates by construction at 128; it never wraps.
REQ-027 x_drv = 0 whenever the FSM is IDLE.

Reset
REQ-028 rst asserted, at any time, forces IDLE immediately: x_drv = 0, busy = 0, done = 0, tt = 0, ones = 0, self_dual = 0, monotone = 0, delay line invalid.
REQ-029 rst mid-SCAN or mid-CHECK discards the partial results; the next start performs a full fresh run.

Configuration
REQ-030 Macro MONO_CHECK_EN.
- Defined: the monotonicity comparisons of REQ-021 are compiled in.
- Undefined: the monotonicity logic is omitted, monotone is tied to 0, CHECK still runs 128 cycles for self_dual, and latency is unchanged.

Verification
REQ-031 f = 0, LAT = 1 -> tt = 0, ones = 0, self_dual = 0, monotone = 1; done exactly 258 cycles after start.
REQ-032 f = MAJ(x0,x1,x2), LAT = 2 -> ones = 64, self_dual = 1, monotone = 1; done 259 cycles after start.
REQ-033 f = x0 XOR x1, LAT = 0 -> ones = 64, self_dual = 0, monotone = 0; tt[1] = 1, tt[3] = 0.
REQ-034 f = 7-input parity -> ones = 64, self_dual = 1, monotone = 0; with MONO_CHECK_EN undefined, monotone = 0 for the MAJ case as well.
REQ-035 start pulsed again at SCAN cycle 50 -> ignored; results identical to a single-start run.
REQ-036 rst at SCAN cycle 70, then start -> all outputs 0 during reset; the new run produces the full correct tt with no stale bits.

Source files
------------

// File: rtl/tt_classify_ctrl.sv
// -----------------------------------------------------------------------------
// tt_classify_ctrl
//
// Purpose:
//   Drives all 128 input patterns of an attached 7-input Boolean function and
//   captures its truth table. It then classifies the function: it counts the
//   ones and checks whether the function is self-dual. Monotonicity is also
//   checked when MONO_CHECK_EN is defined.
//
//   The function's response arrives LAT cycles after x_drv changes. A delay
//   line carrying {valid, index} tags each returning sample with the pattern
//   that produced it.
//
// Configuration:
//   MONO_CHECK_EN - when defined, the per-index monotonicity comparisons are
//                   built and monotone reports the result. When undefined,
//                   monotone is tied low. CHECK still walks all 128 indices
//                   for self_dual, so latency does not change.
//
// Ports:
//   clk        in   1    single rising-edge clock
//   rst        in   1    asynchronous active-high reset
//   start      in   1    one-cycle classify request (honoured only when idle)
//   x_drv      out  7    pattern applied to the function; bit k feeds xk
//   f_val      in   1    function output, valid LAT cycles after x_drv
//   busy       out  1    high from the cycle after an accepted start until done
//   done       out  1    one-cycle pulse when all results are valid
//   tt         out  128  truth table, tt[i] = f(i)
//   ones       out  8    number of ones in tt (0..128)
//   self_dual  out  1    f(~x) == ~f(x) for every x
//   monotone   out  1    raising any single input never lowers f
// -----------------------------------------------------------------------------
module tt_classify_ctrl #(
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic [6:0]   x_drv,
    input  logic         f_val,
    output logic         busy,
    output logic         done,
    output logic [127:0] tt,
    output logic [7:0]   ones,
    output logic         self_dual,
    output logic         monotone
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // DRAIN exits on the cycle whose counter equals this value.
    localparam logic [1:0] DRAIN_LAST = (LAT == 0) ? 2'd0 : 2'(LAT - 1);

    state_t         state_r;
    state_t         next_state_s;
    logic [6:0]     x_drv_r;
    logic [1:0]     drain_cnt_r;
    logic [6:0]     chk_idx_r;
    logic           busy_r;
    logic           done_r;
    logic [127:0]   tt_r;
    logic [7:0]     ones_r;
    logic           sd_r;
    logic           tag_valid_s;
    logic [6:0]     tag_idx_s;
    logic           accept_s;

    assign accept_s = (state_r == ST_IDLE) && start;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_SCAN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (x_drv_r == 7'd127) begin
                    next_state_s = (LAT == 0) ? ST_CHECK : ST_DRAIN;
                end else begin
                    next_state_s = ST_SCAN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_r == DRAIN_LAST) begin
                    next_state_s = ST_CHECK;
                end else begin
                    next_state_s = ST_DRAIN;
                end
            end
            ST_CHECK: begin
                if (chk_idx_r == 7'd127) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_CHECK;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Pattern driver, phase counters and the busy/done flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_drv_r     <= 7'd0;
            drain_cnt_r <= 2'd0;
            chk_idx_r   <= 7'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            // The flags are computed from the next state, so they line up
            // with the state they describe.
            busy_r <= (next_state_s == ST_SCAN) || (next_state_s == ST_DRAIN) ||
                      (next_state_s == ST_CHECK);
            done_r <= (next_state_s == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    x_drv_r     <= 7'd0;
                    drain_cnt_r <= 2'd0;
                    chk_idx_r   <= 7'd0;
                end
                ST_SCAN: begin
                    // x_drv stays at 127 through DRAIN.
                    if (x_drv_r == 7'd127) begin
                        x_drv_r <= 7'd127;
                    end else begin
                        x_drv_r <= x_drv_r + 7'd1;
                    end
                end
                ST_DRAIN: begin
                    drain_cnt_r <= drain_cnt_r + 2'd1;
                end
                ST_CHECK: begin
                    chk_idx_r <= chk_idx_r + 7'd1;
                end
                ST_DONE: begin
                    x_drv_r   <= 7'd0;
                    chk_idx_r <= 7'd0;
                end
                default: begin
                    x_drv_r     <= 7'd0;
                    drain_cnt_r <= 2'd0;
                    chk_idx_r   <= 7'd0;
                end
            endcase
        end
    end

    // Sample-tagging delay line: the tag leaving the last stage names the
    // pattern that the current f_val belongs to.
    generate
        if (LAT == 0) begin : g_no_delay
            assign tag_valid_s = (state_r == ST_SCAN);
            assign tag_idx_s   = x_drv_r;
        end else begin : g_delay
            logic [LAT-1:0] dv_r;
            logic [6:0]     di_r [LAT];

            // Shift the {valid, index} tag one stage per cycle
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dv_r <= {LAT{1'b0}};
                    for (int k = 0; k < LAT; k++) begin
                        di_r[k] <= 7'd0;
                    end
                end else begin
                    dv_r[0] <= (state_r == ST_SCAN);
                    di_r[0] <= x_drv_r;
                    for (int k = 1; k < LAT; k++) begin
                        dv_r[k] <= dv_r[k-1];
                        di_r[k] <= di_r[k-1];
                    end
                end
            end

            assign tag_valid_s = dv_r[LAT-1];
            assign tag_idx_s   = di_r[LAT-1];
        end
    endgenerate

    // Truth-table capture and ones count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tt_r   <= 128'd0;
            ones_r <= 8'd0;
        end else begin
            if (tag_valid_s) begin
                tt_r[tag_idx_s] <= f_val;
                // Each index is written exactly once per run, so the count
                // tops out at 128 and cannot wrap.
                ones_r          <= ones_r + {7'd0, f_val};
            end
            // A new run clears stale results. Tags are never valid in IDLE.
            if (accept_s) begin
                tt_r   <= 128'd0;
                ones_r <= 8'd0;
            end
        end
    end

    // Self-duality: ~i is 127-i for a 7-bit index. Any equal mirror pair
    // disproves the property.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sd_r <= 1'b0;
        end else if (accept_s) begin
            sd_r <= 1'b1;
        end else if ((state_r == ST_CHECK) && (tt_r[chk_idx_r] == tt_r[~chk_idx_r])) begin
            sd_r <= 1'b0;
        end else begin
            sd_r <= sd_r;
        end
    end

`ifdef MONO_CHECK_EN
    logic mono_viol_s;
    logic mono_r;

    // Flags a set bit at chk_idx_r whose single-bit raise in some clear
    // input position reads back as 0
    always_comb begin
        mono_viol_s = 1'b0;
        for (int j = 0; j < 7; j++) begin
            if (!chk_idx_r[j] && tt_r[chk_idx_r] && !tt_r[chk_idx_r | (7'd1 << j)]) begin
                mono_viol_s = 1'b1;
            end else begin
                mono_viol_s = mono_viol_s;
            end
        end
    end

    // Monotonicity flag: set on start, cleared by any violation during CHECK
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mono_r <= 1'b0;
        end else if (accept_s) begin
            mono_r <= 1'b1;
        end else if ((state_r == ST_CHECK) && mono_viol_s) begin
            mono_r <= 1'b0;
        end else begin
            mono_r <= mono_r;
        end
    end

    assign monotone = mono_r;
`else
    assign monotone = 1'b0;
`endif

    assign x_drv     = x_drv_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign tt        = tt_r;
    assign ones      = ones_r;
    assign self_dual = sd_r;

endmodule

// File: tb/tb_tt_classify_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tt_classify_ctrl
//
// Self-checking bench for tt_classify_ctrl. Three instances are built, with
// LAT = 0, 1 and 2. Each instance is fed by a behavioural function model that
// delays its response by that instance's LAT. Table-driven runs push
// expectations to a scoreboard when start is driven and pop them at done.
// Hand-written sequences cover a start during DONE, a second start
// mid-SCAN, and a reset mid-SCAN.
// -----------------------------------------------------------------------------
module tb_tt_classify_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   start;
    logic [2:0]   f_val;
    logic [2:0]   busy;
    logic [2:0]   done;
    logic [2:0]   self_dual;
    logic [2:0]   monotone;
    logic [6:0]   x_drv [3];
    logic [127:0] tt    [3];
    logic [7:0]   ones  [3];

    int           cnt = 0;
    int           checks = 0;
    int           errors = 0;
    int           fsel = 0;
    logic [127:0] rand_tbl = 128'd0;
    logic [6:0]   h1 [3];
    logic [6:0]   h2 [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        tt_classify_ctrl #(.LAT(g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start[g]),
            .x_drv     (x_drv[g]),
            .f_val     (f_val[g]),
            .busy      (busy[g]),
            .done      (done[g]),
            .tt        (tt[g]),
            .ones      (ones[g]),
            .self_dual (self_dual[g]),
            .monotone  (monotone[g])
        );
    end

    // Behavioural function under test
    function automatic logic fn(input int sel, input logic [6:0] x, input logic [127:0] rt);
        case (sel)
            0:       return 1'b0;
            1:       return (x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2]);
            2:       return x[0] ^ x[1];
            3:       return ^x;
            4:       return rt[x];
            5:       return x[6];
            default: return 1'b0;
        endcase
    endfunction

    // Cycle counter and x_drv history (gives the LAT-cycle response delay)
    always @(posedge clk) begin
        cnt <= cnt + 1;
        for (int g = 0; g < 3; g++) begin
            h1[g] <= x_drv[g];
            h2[g] <= h1[g];
        end
    end

    always_comb begin
        f_val[0] = fn(fsel, x_drv[0], rand_tbl);
        f_val[1] = fn(fsel, h1[1], rand_tbl);
        f_val[2] = fn(fsel, h2[2], rand_tbl);
    end

    // Reference model built directly from the property definitions
    function automatic logic [127:0] mk_tt(input int sel, input logic [127:0] rt);
        logic [127:0] t;
        for (int i = 0; i < 128; i++) t[i] = fn(sel, 7'(i), rt);
        return t;
    endfunction

    function automatic logic is_sd(input logic [127:0] t);
        logic r = 1'b1;
        for (int i = 0; i < 128; i++) if (t[i] == t[127 - i]) r = 1'b0;
        return r;
    endfunction

    function automatic logic is_mono(input logic [127:0] t);
        logic r = 1'b1;
        for (int i = 0; i < 128; i++)
            for (int j = 0; j < 7; j++)
                if (((i >> j) & 1) == 0 && t[i] && !t[i | (1 << j)]) r = 1'b0;
        return r;
    endfunction

    typedef struct {
        int lat;
        int sel;
        int e_ones;   // -1: derive from the model
        int e_sd;
        int e_mono;
    } vec_t;

    typedef struct {
        logic [127:0] tt;
        logic [7:0]   ones;
        logic         sd;
        logic         mono;
        int           lat_cyc;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs [7];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int g, input int sel, input int e_ones, input int e_sd,
                            input int e_mono);
        exp_t e;
        e.tt      = mk_tt(sel, rand_tbl);
        e.ones    = (e_ones < 0) ? 8'($countones(e.tt)) : 8'(e_ones);
        e.sd      = (e_sd < 0) ? is_sd(e.tt) : (e_sd != 0);
`ifdef MONO_CHECK_EN
        e.mono    = (e_mono < 0) ? is_mono(e.tt) : (e_mono != 0);
`else
        e.mono    = 1'b0;
`endif
        e.lat_cyc = 257 + g;
        sb_q.push_back(e);
    endtask

    // Pulse start for one cycle on instance g. Returns at cycle 1 (first SCAN).
    task automatic launch(input int g, output int t0);
        @(negedge clk);
        start[g] = 1'b1;
        t0 = cnt;
        @(negedge clk);
        start[g] = 1'b0;
        chk("busy_after_start", 128'(busy[g]), 128'd1);
        chk("x_drv_first_scan", 128'(x_drv[g]), 128'd0);
    endtask

    // Wait (bounded) for done and compare against the scoreboard head.
    // Returns on the negedge of the done cycle.
    task automatic finish_run(input int g, input int t0);
        exp_t e;
        int   n = 0;
        while (done[g] !== 1'b1 && n < 700) begin
            @(negedge clk);
            n++;
        end
        if (done[g] !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: dut %0d no done after %0d cycles", g, n);
            if (sb_q.size() > 0) e = sb_q.pop_front();
        end else if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: dut %0d done with no expectation", g);
        end else begin
            e = sb_q.pop_front();
            chk("latency", 128'(cnt - t0), 128'(e.lat_cyc));
            chk("tt", tt[g], e.tt);
            chk("ones", 128'(ones[g]), 128'(e.ones));
            chk("self_dual", 128'(self_dual[g]), 128'(e.sd));
            chk("monotone", 128'(monotone[g]), 128'(e.mono));
            chk("busy_in_done", 128'(busy[g]), 128'd0);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   t0;
        logic [127:0] hold_tt;

        vecs[0] = '{1, 0,  0,  0,  1};   // constant 0
        vecs[1] = '{2, 1, 64,  1,  1};   // MAJ(x0,x1,x2)
        vecs[2] = '{0, 2, 64,  0,  0};   // x0 ^ x1
        vecs[3] = '{1, 3, 64,  1,  0};   // 7-input parity
        vecs[4] = '{2, 5, 64,  1,  1};   // x6
        vecs[5] = '{0, 1, 64,  1,  1};   // MAJ with no latency
        vecs[6] = '{1, 4, -1, -1, -1};   // random table

        rst   = 1'b1;
        start = 3'b000;
        rand_tbl = {$urandom(), $urandom(), $urandom(), $urandom()};
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk("reset_ctrl", {x_drv[g], busy[g], done[g], ones[g], self_dual[g], monotone[g]},
                128'd0);
            chk("reset_tt", tt[g], 128'd0);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Table-driven runs
        for (int v = 0; v < 7; v++) begin
            fsel = vecs[v].sel;
            push_exp(vecs[v].lat, vecs[v].sel, vecs[v].e_ones, vecs[v].e_sd, vecs[v].e_mono);
            launch(vecs[v].lat, t0);
            finish_run(vecs[v].lat, t0);
        end

        // Start during DONE is ignored, and results hold afterwards
        fsel = 2;
        push_exp(0, 2, 64, 0, 0);
        hold_tt = mk_tt(2, rand_tbl);
        launch(0, t0);
        finish_run(0, t0);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        chk("done_one_pulse", 128'(done[0]), 128'd0);
        repeat (4) @(negedge clk);
        chk("idle_after_done_start", 128'(busy[0]), 128'd0);
        chk("idle_x_drv", 128'(x_drv[0]), 128'd0);
        chk("hold_tt", tt[0], hold_tt);
        chk("hold_ones", 128'(ones[0]), 128'd64);
        chk("tt_bit1_bit3", {126'd0, tt[0][1], tt[0][3]}, 128'd2);

        // Second start at SCAN cycle 50 is ignored
        fsel = 1;
        push_exp(1, 1, 64, 1, 1);
        launch(1, t0);
        repeat (49) @(negedge clk);
        chk("x_drv_cycle50", 128'(x_drv[1]), 128'd49);
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        finish_run(1, t0);

        // Reset at SCAN cycle 70, then a fresh run with a different function
        fsel = 4;
        push_exp(2, 4, -1, -1, -1);
        launch(2, t0);
        repeat (69) @(negedge clk);
        chk("x_drv_cycle70", 128'(x_drv[2]), 128'd69);
        rst = 1'b1;
        #1;
        chk("rst_ctrl", {x_drv[2], busy[2], done[2], ones[2], self_dual[2], monotone[2]}, 128'd0);
        chk("rst_tt", tt[2], 128'd0);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        fsel = 5;
        push_exp(2, 5, 64, 1, 1);
        launch(2, t0);
        finish_run(2, t0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
